// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the product-node multiplier and the sum-node adder.
package bf16_pkg;
  localparam int BF16_W = 16;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 7;
  localparam int BIAS   = 127;

  localparam logic [BF16_W-1:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0]  BF16_INF_EXP = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } bf16_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} bf16_cls_e;

  // Subnormals are flushed, so exp==0 always classifies as zero.
  function automatic bf16_cls_e bf16_classify(input bf16_t v);
    if (v.exp == '0)
      return ZERO;
    else if (v.exp == BF16_INF_EXP)
      return (v.man == '0) ? INF : NAN;
    else
      return NORM;
  endfunction
endpackage

// File: rtl/bf16_operand_slot.sv
// One-entry holding register for a single operand; refills on the same edge it issues.
module bf16_operand_slot
  import bf16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BF16_W-1:0] d,
  input  logic              vld,
  input  logic              issue,
  output logic              rdy,
  output logic              full,
  output logic [BF16_W-1:0] q
);
  assign rdy = !full || issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (vld && rdy) begin
      full <= 1'b1;
      q    <= d;
    end else if (issue) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/bf16_mul_node.sv
// Pipelined bfloat16 multiplier (pair slots, S1 unpack, S2 multiply, Z normalise/round).
// Define BF16_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module bf16_mul_node
  import bf16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BF16_W-1:0] a,
  input  logic              a_vld,
  output logic              a_rdy,
  input  logic [BF16_W-1:0] b,
  input  logic              b_vld,
  output logic              b_rdy,
  output logic [BF16_W-1:0] z,
  output logic              z_vld,
  input  logic              z_rdy
);
  logic adv, issue, a_full, b_full;
  logic [BF16_W-1:0] a_q, b_q;

  assign adv   = !z_vld || z_rdy;
  assign issue = a_full && b_full && adv;

  bf16_operand_slot u_slot_a (
    .clk(clk), .rst(rst), .d(a), .vld(a_vld), .issue(issue),
    .rdy(a_rdy), .full(a_full), .q(a_q)
  );

  bf16_operand_slot u_slot_b (
    .clk(clk), .rst(rst), .d(b), .vld(b_vld), .issue(issue),
    .rdy(b_rdy), .full(b_full), .q(b_q)
  );

  // S1 inputs: unpack and resolve special operands up front
  bf16_t ua, ub;
  bf16_cls_e ca, cb;
  logic sign_n, spec_n;
  logic [BF16_W-1:0] sval_n;
  logic signed [9:0] esum_n;

  assign ua = bf16_t'(a_q);
  assign ub = bf16_t'(b_q);
  assign ca = bf16_classify(ua);
  assign cb = bf16_classify(ub);
  assign sign_n = ua.sign ^ ub.sign;
  assign esum_n = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;

  always_comb begin
    spec_n = 1'b1;
    sval_n = '0;
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == INF) || (ca == INF && cb == ZERO))
      sval_n = BF16_QNAN;
    else if (ca == INF || cb == INF)
      sval_n = {sign_n, BF16_INF_EXP, {MAN_W{1'b0}}};
    else if (ca == ZERO || cb == ZERO)
      sval_n = {sign_n, {(BF16_W-1){1'b0}}};
    else
      spec_n = 1'b0;
  end

  logic s1_vld, s1_sign, s1_spec;
  logic signed [9:0] s1_exp;
  logic [7:0] s1_ma, s1_mb;
  logic [BF16_W-1:0] s1_sval;

  logic s2_vld, s2_sign, s2_spec;
  logic signed [9:0] s2_exp;
  logic [15:0] s2_prod;
  logic [BF16_W-1:0] s2_sval;

  // Z stage: normalise, round, renormalise, saturate
  logic [MAN_W-1:0] man_n;
  logic signed [9:0] exp_n, exp_f;
  logic round_up;
  logic [7:0] mant_sum;
  logic [BF16_W-1:0] res_n;

  always_comb begin
    if (s2_prod[15]) begin
      man_n = s2_prod[14:8];
      exp_n = s2_exp + 10'sd1;
    end else begin
      man_n = s2_prod[13:7];
      exp_n = s2_exp;
    end
  end

`ifdef BF16_MUL_RNE_EN
  logic guard, sticky;
  assign guard    = s2_prod[15] ? s2_prod[7] : s2_prod[6];
  assign sticky   = s2_prod[15] ? |s2_prod[6:0] : |s2_prod[5:0];
  assign round_up = guard && (sticky || man_n[0]);
`else
  assign round_up = 1'b0;
`endif

  assign mant_sum = {1'b0, man_n} + {7'd0, round_up};
  assign exp_f    = exp_n + $signed({9'd0, mant_sum[7]});

  always_comb begin
    if (s2_spec)
      res_n = s2_sval;
    else if (exp_f >= 10'sd255)
      res_n = {s2_sign, BF16_INF_EXP, {MAN_W{1'b0}}};
    else if (exp_f <= 10'sd0)
      res_n = {s2_sign, {(BF16_W-1){1'b0}}};
    else
      res_n = {s2_sign, exp_f[EXP_W-1:0], mant_sum[MAN_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_spec <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_sval <= '0;
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_spec <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_sval <= '0;
      z_vld   <= 1'b0;
      z       <= '0;
    end else if (adv) begin
      s1_vld  <= issue;
      s1_sign <= sign_n;
      s1_spec <= spec_n;
      s1_exp  <= esum_n;
      s1_ma   <= {1'b1, ua.man};
      s1_mb   <= {1'b1, ub.man};
      s1_sval <= sval_n;
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_spec <= s1_spec;
      s2_exp  <= s1_exp;
      s2_prod <= s1_ma * s1_mb;
      s2_sval <= s1_sval;
      z_vld   <= s2_vld;
      if (s2_vld)
        z <= res_n;
    end
  end
endmodule

// File: tb/tb_bf16_mul_node.sv
// Self-checking bench for bf16_mul_node: directed latency/slot/special/reset steps plus randomized streams.
module tb_bf16_mul_node;
  logic        clk, rst;
  logic [15:0] a, b, z;
  logic        a_vld, a_rdy, b_vld, b_rdy, z_vld, z_rdy;

  int checks = 0;
  int errors = 0;

  logic [15:0] pa[64], pb[64], pz[64];

  bf16_mul_node dut (
    .clk(clk), .rst(rst),
    .a(a), .a_vld(a_vld), .a_rdy(a_rdy),
    .b(b), .b_vld(b_vld), .b_rdy(b_rdy),
    .z(z), .z_vld(z_vld), .z_rdy(z_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product of the significands, then normalise by its MSB position.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, e, k, sh;
    longint p, mant;
    bit s, zx, zy, ix, iy, nx, ny;
    logic [15:0] r;
    ex = int'(x[14:7]);
    ey = int'(y[14:7]);
    s  = x[15] ^ y[15];
    zx = (ex == 0);   zy = (ey == 0);
    ix = (ex == 255) && (x[6:0] == 0);
    iy = (ey == 255) && (y[6:0] == 0);
    nx = (ex == 255) && (x[6:0] != 0);
    ny = (ey == 255) && (y[6:0] != 0);
    if (nx || ny || (zx && iy) || (ix && zy)) return 16'h7FC0;
    if (ix || iy) return {s, 8'hFF, 7'h0};
    if (zx || zy) return {s, 15'h0};
    p = longint'(128 + int'(x[6:0])) * longint'(128 + int'(y[6:0]));
    k = 0;
    for (int i = 0; i < 32; i++) if (((p >> i) & 1) == 1) k = i;
    e = ex + ey - 127 + (k - 14);
    sh = k - 7;
    mant = p >> sh;
`ifdef BF16_MUL_RNE_EN
    begin
      longint rem, half;
      rem  = p - (mant << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
    end
`endif
    if (mant == 256) begin
      mant = 128;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 7'h0};
    if (e <= 0) return {s, 15'h0};
    r = {s, e[7:0], mant[6:0]};
    return r;
  endfunction

  // mode 0: z_rdy always 1; mode 1: z_rdy toggles; mode 2: random z_rdy and input gaps
  task automatic run_stream(input int n, input int mode, input string tag);
    int ai = 0, bi = 0, zi = 0, cyc = 0;
    bit held = 0, tog = 1, extra = 0;
    logic [15:0] hz = '0;
    while (zi < n && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        chk({tag, "_hold_z"}, z, hz);
        chk({tag, "_hold_vld"}, {15'd0, z_vld}, 16'd1);
      end
      z_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom % 2);
      tog = !tog;
      if (ai < n && (a_vld || mode != 2 || ($urandom % 4) != 0)) begin
        a_vld = 1'b1; a = pa[ai];
      end else a_vld = 1'b0;
      if (bi < n && (b_vld || mode != 2 || ($urandom % 4) != 0)) begin
        b_vld = 1'b1; b = pb[bi];
      end else b_vld = 1'b0;
      #1;
      if (a_vld && a_rdy) ai++;
      if (b_vld && b_rdy) bi++;
      held = 0;
      if (z_vld) begin
        if (z_rdy) begin
          $display("%s #%0d: %h * %h -> z=%h (expected %h)", tag, zi, pa[zi], pb[zi], z, pz[zi]);
          chk(tag, z, pz[zi]);
          zi++;
        end else begin
          held = 1;
          hz = z;
        end
      end
    end
    a_vld = 1'b0; b_vld = 1'b0; z_rdy = 1'b1;
    checks++;
    assert (zi == n) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d results", tag, zi, n);
    end
    repeat (6) begin
      @(negedge clk);
      if (z_vld) extra = 1;
    end
    chk({tag, "_no_extra"}, {15'd0, extra}, 16'd0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [15:0] e3fc1;
    rst = 1'b1; a = '0; b = '0; a_vld = 0; b_vld = 0; z_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_z", z, 16'h0000);
    chk("reset_zvld", {15'd0, z_vld}, 16'd0);
    chk("reset_ardy", {15'd0, a_rdy}, 16'd1);
    chk("reset_brdy", {15'd0, b_rdy}, 16'd1);
    rst = 1'b0;
    @(negedge clk);

    // Latency: both operands in the same cycle -> z_vld exactly 3 edges after accept
    a = 16'h3F80; b = 16'h4000; a_vld = 1; b_vld = 1;
    #1 chk("lat_ardy", {15'd0, a_rdy}, 16'd1);
    @(negedge clk); a_vld = 0; b_vld = 0;
    chk("lat_k0", {15'd0, z_vld}, 16'd0);
    @(negedge clk); chk("lat_k1", {15'd0, z_vld}, 16'd0);
    @(negedge clk); chk("lat_k2", {15'd0, z_vld}, 16'd0);
    @(negedge clk); chk("lat_k3", {15'd0, z_vld}, 16'd1);
    chk("lat_z", z, 16'h4000);
    @(negedge clk); chk("lat_drop", {15'd0, z_vld}, 16'd0);

    // A waits in its slot; a different held value must not overwrite it
    a = 16'h3FC0; a_vld = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a = 16'h4000;
      #1 chk("slot_ardy_low", {15'd0, a_rdy}, 16'd0);
    end
    @(negedge clk); a_vld = 0; b = 16'h3FC0; b_vld = 1;
    @(negedge clk); b_vld = 0;
    #1 chk("slot_issue_ardy", {15'd0, a_rdy}, 16'd1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (z_vld) ok = 1;
    end
    chk("slot_seen", {15'd0, ok}, 16'd1);
    chk("slot_z", z, 16'h4010);
    @(negedge clk);

    // Directed values and special cases
`ifdef BF16_MUL_RNE_EN
    e3fc1 = 16'h4012;
`else
    e3fc1 = 16'h4011;
`endif
    pa[0] = 16'hC040; pb[0] = 16'h4000; pz[0] = 16'hC0C0;
    pa[1] = 16'h3FC1; pb[1] = 16'h3FC1; pz[1] = e3fc1;
    pa[2] = 16'h7FC0; pb[2] = 16'h3F80; pz[2] = 16'h7FC0;
    pa[3] = 16'h0000; pb[3] = 16'h7F80; pz[3] = 16'h7FC0;
    pa[4] = 16'h7F00; pb[4] = 16'h7F00; pz[4] = 16'h7F80;
    pa[5] = 16'h0080; pb[5] = 16'h0080; pz[5] = 16'h0000;
    pa[6] = 16'h8000; pb[6] = 16'h3F80; pz[6] = 16'h8000;
    pa[7] = 16'hFF80; pb[7] = 16'h4000; pz[7] = 16'hFF80;
    run_stream(8, 0, "directed");

    // 8 back-to-back pairs with z_rdy toggling
    for (int i = 0; i < 8; i++) begin
      pa[i] = {1'($urandom), 8'(100 + $urandom % 55), 7'($urandom)};
      pb[i] = {1'($urandom), 8'(100 + $urandom % 55), 7'($urandom)};
      pz[i] = ref_mul(pa[i], pb[i]);
    end
    run_stream(8, 1, "toggle");

    // Randomized stream with occasional special exponents and extreme ranges
    n = 40;
    for (int i = 0; i < n; i++) begin
      int ea, eb;
      ea = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : 255) : 20 + int'($urandom % 220);
      eb = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : 255) : 20 + int'($urandom % 220);
      pa[i] = {1'($urandom), 8'(ea), 7'($urandom)};
      pb[i] = {1'($urandom), 8'(eb), 7'($urandom)};
      pz[i] = ref_mul(pa[i], pb[i]);
    end
    run_stream(n, 2, "random");

    // Reset with one result parked in z and another still in the pipeline
    z_rdy = 0;
    a = 16'h3F80; b = 16'h3F80; a_vld = 1; b_vld = 1;
    @(negedge clk); a = 16'h4000; b = 16'h4000;
    @(negedge clk); a_vld = 0; b_vld = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_vld", {15'd0, z_vld}, 16'd1);
    chk("rst_pre_z", z, 16'h3F80);
    #2 rst = 1'b1;
    #1 chk("rst_async_vld", {15'd0, z_vld}, 16'd0);
    chk("rst_async_z", z, 16'h0000);
    @(negedge clk); rst = 1'b0; z_rdy = 1'b1;
    ok = 0;
    repeat (8) begin
      @(negedge clk);
      if (z_vld) ok = 1;
    end
    chk("rst_no_stale", {15'd0, ok}, 16'd0);
    chk("rst_post_ardy", {15'd0, a_rdy}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bf16_mul_node.md
Name: bf16_mul_node

Overview:
- Pipelined bfloat16 multiplier for probabilistic-circuit product nodes; sits directly upstream of the bf16 sum-node adder and drives its a/a_vld (or b/b_vld) inputs.
- Operands a and b arrive independently with their own valid strobes. Each is held in a one-entry slot until its partner arrives, then the pair is issued into a 3-register pipeline.
- Output is a registered z/z_vld pair with z_rdy backpressure.

Parameters:
- EXP_W, 8, exponent width (bf16 fixed; parameterised only for the package constants)
- MAN_W, 7, stored mantissa width
- BIAS, 127, exponent bias

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a  in  16  operand A (sign[15], exp[14:7], man[6:0])
- a_vld  in  1  A valid
- a_rdy  out  1  A slot can accept this cycle
- b  in  16  operand B
- b_vld  in  1  B valid
- b_rdy  out  1  B slot can accept this cycle
- z  out  16  product
- z_vld  out  1  product valid
- z_rdy  in  1  downstream accepts z

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: a_full=0, b_full=0, all stage valids 0, z=16'h0000, z_vld=0.
- Global advance: adv = !z_vld || z_rdy. When adv=0, every pipeline register holds its value.
- Issue: issue = a_full && b_full && adv. On issue, both slots clear and the pair loads into stage S1.
- Ready signals: a_rdy = !a_full || issue, and b_rdy likewise. These are combinational from z_rdy.
- Accept: the A slot captures a when a_vld && a_rdy. Same rule for B. Capture and issue may happen on the same edge (refill), giving 1 result/cycle sustained.
- Pipeline stages:
  - S1: unpack; classify zero/inf/NaN; compute sign = sa^sb; compute exp sum ea+eb-BIAS into a 10-bit signed value.
  - S2: 8x8 unsigned product of hidden-bit mantissas (16 bits).
  - Z: normalise. If prod[15]=1, shift right by 1 and add 1 to the exponent. Then round, renormalise on mantissa carry, and pack into the z register.
- Latency: a pair fully accepted on edge k gives z_vld=1 after edge k+3 when there is no stall. The result holds until z_vld && z_rdy.
- Special cases (IEEE-like, flush-to-zero):
  - A subnormal input (exp=0) is treated as zero.
  - NaN input, or 0 x inf: z = 16'h7FC0 (canonical quiet NaN, sign 0).
  - inf x finite non-zero: signed inf, {sign, 8'hFF, 7'h0}.
  - zero x finite: signed zero, {sign, 15'h0}.
  - Final exponent >= 255: signed inf.
  - Final exponent <= 0: signed zero. No subnormal outputs are produced.
- Boundary conditions:
  - A slot full and new a_vld arrives while no issue: a_rdy=0, and the upstream must hold a. Slot contents are never overwritten.
  - a_vld and b_vld in the same cycle with both slots empty: both are captured, and issue follows on the next edge.
  - Reset mid-operation: the slots and all in-flight products are discarded. No z_vld appears afterwards for them.

Optional Feature:
- Macro BF16_MUL_RNE_EN.
- Defined: round-to-nearest-even using guard plus sticky (OR of the remaining product bits); the tie rounds to an even LSB.
- Undefined: truncation (round toward zero); guard and sticky logic is removed.
- Latency and handshake are identical in both builds.

Decomposition:
- Package bf16_pkg holds:
  - constants BF16_W=16, EXP_W, MAN_W, BIAS, BF16_QNAN=16'h7FC0, BF16_INF_EXP=8'hFF;
  - a packed struct typedef {sign, exp, man};
  - a class enum {ZERO, NORM, INF, NAN}.
- The package is shared with bf16_adder1.
- One sub-module, bf16_operand_slot: a 1-entry vld/rdy holding register. It is instantiated twice, for A and B.

Test Plan:
- a=3F80 (1.0) and b=4000 (2.0) in the same cycle, z_rdy=1 -> z=4000, z_vld high exactly 3 edges after accept; C040 x 4000 -> C0C0.
- a=3FC0 at t0, b=3FC0 at t0+5 cycles -> a_rdy=0 after the first accept, issue follows B's accept, z=4010 (2.25).
- 3FC1 x 3FC1 -> 4012 with BF16_MUL_RNE_EN, 4011 without it.
- Specials:
  - 7FC0 x 3F80 -> 7FC0
  - 0000 x 7F80 -> 7FC0
  - 7F00 x 7F00 -> 7F80
  - 0080 x 0080 -> 0000
  - 8000 x 3F80 -> 8000
- Stream 8 back-to-back pairs with z_rdy toggling 1/0 each cycle -> all 8 results emitted in order, z stable while z_vld && !z_rdy, none lost or duplicated.
- Assert rst for 1 cycle while 2 products are in flight -> z_vld=0 and z=0000 immediately after assertion; no stale outputs after release.
